// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sequential single-multiplier FIR; one saturated Q1.(DATABITS-1) output per input sample.
// Walks the taps one per cycle, addressing the coefficient memory directly.
module fir_mac_engine #(
    parameter int CMEMSIZE = 8,
    parameter int DATABITS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATABITS-1:0]         in_data,
    output logic [$clog2(CMEMSIZE)-1:0] cmem_addr_out,
    input  logic [DATABITS-1:0]         coef_in,
    input  logic                        sde_in,
    output logic                        busy_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATABITS-1:0]         out_data
);
    localparam int AW = $clog2(CMEMSIZE);
    localparam int ACCBITS = 2*DATABITS + AW;
    localparam logic signed [ACCBITS-1:0] SMAX = {{(ACCBITS-DATABITS+1){1'b0}}, {(DATABITS-1){1'b1}}};
    localparam logic signed [ACCBITS-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                      state_q, state_d;
    logic signed [DATABITS-1:0]  x_q [CMEMSIZE];
    logic signed [ACCBITS-1:0]   acc_q, acc_d, acc_shr;
    logic [AW-1:0]               tap_q;
    logic [DATABITS-1:0]         out_q, sat_d;
    logic [2*DATABITS-1:0]       prod;
    logic                        accept, last;

    assign accept = in_valid && in_ready;
    assign last   = tap_q == AW'(CMEMSIZE-1);
    // Operands sign-extended to full width so the truncated product is the exact signed product
    assign prod    = {{DATABITS{x_q[tap_q][DATABITS-1]}}, x_q[tap_q]} * {{DATABITS{coef_in[DATABITS-1]}}, coef_in};
    assign acc_d   = acc_q + {{AW{prod[2*DATABITS-1]}}, prod};
    assign acc_shr = acc_d >>> (DATABITS-1);
    assign sat_d   = acc_shr > SMAX ? SMAX[DATABITS-1:0] :
                     acc_shr < SMIN ? SMIN[DATABITS-1:0] : acc_shr[DATABITS-1:0];

    assign in_ready      = rst_n && state_q == IDLE && !sde_in;
    assign busy_out      = state_q != IDLE;
    assign out_valid     = state_q == DONE;
    assign out_data      = out_q;
    assign cmem_addr_out = state_q == MAC ? tap_q : '0;

    always_comb begin
        state_d = (state_q == IDLE && accept)    ? MAC  :
                  (state_q == MAC && last)       ? DONE :
                  (state_q == DONE && out_ready) ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tap_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < CMEMSIZE; i++) x_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept) begin
                x_q[0] <= in_data;
                for (int i = 1; i < CMEMSIZE; i++) x_q[i] <= x_q[i-1];
                acc_q <= '0;
                tap_q <= '0;
            end else if (state_q == MAC) begin
                acc_q <= acc_d;
                tap_q <= last ? '0 : tap_q + AW'(1);
                if (last) out_q <= sat_d;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: scoreboard bench; a plain-arithmetic FIR model predicts every output sample.
module tb_fir_mac_engine;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_data = 0;
    logic [2:0]  cmem_addr_out;
    logic [15:0] coef_in;
    logic        sde_in = 0;
    logic        busy_out;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] out_data;

    logic [15:0] coef_mem [8];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          hist [8];
    int          total = 0;
    int          bad = 0;
    bit          rand_bp = 0;

    fir_mac_engine #(.CMEMSIZE(8), .DATABITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmem_addr_out(cmem_addr_out), .coef_in(coef_in), .sde_in(sde_in), .busy_out(busy_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    assign coef_in = coef_mem[cmem_addr_out];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // y = clamp(floor(sum(x[i]*c[i]) / 2^15)) over the newest eight samples
    function automatic void model_accept(input logic [15:0] d);
        longint s = 0;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(d));
        for (int i = 0; i < 8; i++) s += longint'(hist[i]) * longint'($signed(coef_mem[i]));
        s = s >>> 15;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        exp_q.push_back(16'(s));
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got=%h want=none", out_data);
            end else
                check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            got_q.push_back(out_data);
        end
        if (sde_in && busy_out) begin
            total++;
            bad++;
            $display("FAIL loader_shift_while_busy: got=1 want=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [15:0] d);
        bit ok = 0;
        bit rdy;
        in_valid = 1;
        in_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (rdy) begin
                ok = 1;
                model_accept(d);
            end
        end
        in_valid = 0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got=no_accept want=accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got=%0d pending want=0", exp_q.size());
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 8; i++) hist[i] = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_model();
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'h0, in_ready}, 0);
        check({tag, "_busy"}, {31'h0, busy_out}, 0);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 0);
        check({tag, "_addr"}, {29'h0, cmem_addr_out}, 0);
        check({tag, "_out_data"}, {16'h0, out_data}, 0);
    endtask

    task automatic run_impulse(input string tag);
        int base = got_q.size();
        for (int i = 0; i < 8; i++) coef_mem[i] = 16'h4000;
        send(16'h7FFF);
        repeat (8) send(16'h0000);
        drain();
        for (int i = 0; i < 9; i++)
            check({tag, "_impulse"}, (base + i < got_q.size()) ? {16'h0, got_q[base+i]} : 32'hDEADBEEF,
                  i < 8 ? 32'h3FFF : 32'h0000);
    endtask

    initial begin
        logic [15:0] held;
        int          n_got;
        for (int i = 0; i < 8; i++) coef_mem[i] = 0;
        clear_model();
        #3;
        check_reset_outputs("reset");
        do_reset();

        run_impulse("fresh");

        // Latency, addressing and backpressure
        out_ready = 0;
        send(16'h1234);
        for (int i = 0; i < 8; i++) begin
            check("mac_addr", {29'h0, cmem_addr_out}, i);
            check("mac_busy", {31'h0, busy_out}, 1);
            check("mac_in_ready", {31'h0, in_ready}, 0);
            check("mac_out_valid", {31'h0, out_valid}, 0);
            tick();
        end
        check("latency_out_valid", {31'h0, out_valid}, 1);
        check("done_addr", {29'h0, cmem_addr_out}, 0);
        held = out_data;
        in_valid = 1;
        in_data  = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'h0, out_valid}, 1);
            check("bp_out_data", {16'h0, out_data}, {16'h0, held});
            check("bp_in_ready", {31'h0, in_ready}, 0);
            check("bp_busy", {31'h0, busy_out}, 1);
        end
        in_valid = 0;
        n_got = got_q.size();
        out_ready = 1;
        tick();
        check("release_out_valid", {31'h0, out_valid}, 0);
        check("release_busy", {31'h0, busy_out}, 0);
        tick();
        check("one_transfer", got_q.size(), n_got + 1);
        check("idle_in_ready", {31'h0, in_ready}, 1);

        // Load interlock
        sde_in = 1;
        in_valid = 1;
        in_data = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sde_in_ready", {31'h0, in_ready}, 0);
            check("sde_busy", {31'h0, busy_out}, 0);
        end
        sde_in = 0;
        @(negedge clk);
        check("sde_drop_in_ready", {31'h0, in_ready}, 1);
        tick();
        model_accept(16'h4000);
        in_valid = 0;
        check("sde_drop_accepted", {31'h0, busy_out}, 1);
        drain();

        // Saturation
        do_reset();
        for (int i = 0; i < 8; i++) coef_mem[i] = 16'h7FFF;
        repeat (8) send(16'h7FFF);
        drain();
        check("sat_pos", {16'h0, got_q[$]}, 32'h7FFF);
        do_reset();
        repeat (8) send(16'h8000);
        drain();
        check("sat_neg", {16'h0, got_q[$]}, 32'h8000);

        // Reset during MAC aborts without output
        n_got = got_q.size();
        send(16'h2222);
        repeat (3) tick();
        check("pre_reset_addr", {29'h0, cmem_addr_out}, 3);
        rst_n = 0;
        clear_model();
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) tick();
        rst_n = 1;
        repeat (12) tick();
        check("aborted_no_output", got_q.size(), n_got);
        run_impulse("after_reset");

        // Random coefficients, samples and backpressure
        for (int i = 0; i < 8; i++) coef_mem[i] = 16'($urandom);
        rand_bp = 1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: send(16'h7FFF);
                1: send(16'h8000);
                default: send(16'($urandom));
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        rand_bp = 0;
        out_ready = 1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Sequential single-multiplier FIR datapath. It sits directly downstream of the coefficient memory (cmem) and drives that block's read address.
- For each accepted input sample it shifts the sample into a CMEMSIZE-deep delay line. It then walks taps 0..CMEMSIZE-1 one per cycle, multiply-accumulating x[i]*coef[i].
- It emits one saturated, scaled output sample per input over a valid/ready handshake.
- busy_out lets the coefficient loader avoid shifting cmem mid-computation.

Parameters:
- CMEMSIZE, myfilter_pkg value (bench: 8): number of taps; delay-line depth; cmem depth.
- DATABITS, myfilter_pkg value (bench: 16): signed sample, coefficient and output width (Q1.(DATABITS-1)).
- ACCBITS, 2*DATABITS+$clog2(CMEMSIZE) (derived localparam): accumulator width; overflow impossible.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DATABITS  signed input sample.
- cmem_addr_out  out  $clog2(CMEMSIZE)  coefficient read address to cmem addr_in.
- coef_in  in  DATABITS  signed coefficient from cmem d_out; combinational, same cycle as address.
- sde_in  in  1  coefficient shift-load enable (same net as cmem sde_in).
- busy_out  out  1  computation in progress; loader must not shift.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATABITS  signed saturated result.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, delay line x[0..N-1]=0, acc=0, tap=0.
  - Outputs: cmem_addr_out=0, out_valid=0, out_data=0, busy_out=0, in_ready=0 (forced low while rst_n=0).
  - Reset mid-operation aborts with no output.
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready = !sde_in. busy_out=0.
  - On in_valid && in_ready at an edge: x[0]<=in_data, x[i]<=x[i-1]; acc<=0; tap<=0; go to MAC.
  - in_valid while sde_in=1 is ignored, and the sample is held by the source.
- MAC:
  - in_ready=0, busy_out=1, cmem_addr_out=tap.
  - Each edge: acc <= acc + sign-extended(x[tap]*coef_in) (full 2*DATABITS signed product); tap<=tap+1.
  - On the edge where tap==CMEMSIZE-1: latch out_data=sat(acc_final >>> (DATABITS-1)), then go to DONE.
  - Shift is arithmetic (floor, no rounding). Saturation clamps to [-2^(DATABITS-1), 2^(DATABITS-1)-1].
- DONE:
  - out_valid=1, busy_out=1, in_ready=0. out_data is held stable until out_ready=1.
  - On out_valid && out_ready: out_valid<=0, go to IDLE.
  - A new sample is not accepted in the same cycle (in_ready is 0 in DONE).
- Outside MAC, cmem_addr_out=0.
- Latency: sample accepted at edge k → out_valid high after edge k+CMEMSIZE. Throughput is at most one sample per CMEMSIZE+2 cycles.
- sde_in only gates acceptance in IDLE. Asserting it during MAC/DONE is a loader protocol violation. The engine does not abort, and the result is unspecified (bench asserts loader honours busy_out).
- The delay line persists across samples; only reset clears it.

Test Plan:
- Impulse: coefs all 0x4000; send 0x7FFF, then 8× 0x0000 → outputs 1..8 = 0x3FFF, output 9 = 0x0000.
- Saturation: coefs all 0x7FFF.
  - Send 8× 0x7FFF → output 8 = 0x7FFF (clamped).
  - After reset, send 8× 0x8000 → output 8 = 0x8000 (clamped).
- Latency/addressing:
  - Accept at edge k → cmem_addr_out sequences 0..7 on cycles k+1..k+8; out_valid at k+9.
  - busy_out high k+1 through the handshake; in_ready low throughout.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid/out_data stable; in_valid=1 not accepted. Release → exactly one transfer, then return to IDLE.
- Load interlock: sde_in=1 in IDLE with in_valid=1 for 10 cycles → in_ready=0, no state change. Drop sde_in → sample accepted on the next edge.
- Reset mid-MAC: pull rst_n low at tap 3 → all outputs go to their reset values immediately. Release, then run the impulse test → results identical to a fresh run.
